// File: rtl/mpu_bus_bridge_pkg.sv
// Shared definitions for the host-bus to MPU-bus bridge: FSM encoding and byte-lane enables.
package mpu_bus_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_HOLD = 3'd4
  } state_e;

  localparam logic [1:0] BE_EVEN = 2'b01;
  localparam logic [1:0] BE_ODD  = 2'b10;

  function automatic logic [1:0] be_for(input logic addr_lsb);
    return addr_lsb ? BE_ODD : BE_EVEN;
  endfunction

endpackage

// File: rtl/bus_synchronizer.sv
// Two-flop synchroniser for a bundle of asynchronous inputs, with a per-bit reset value.
module bus_synchronizer #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s1 = s1_q;
  assign s2 = s2_q;

endmodule

// File: rtl/mpu_bus_bridge.sv
// Bridges the host 8-bit multiplexed external-memory bus onto the 16-bit MPU word bus.
module mpu_bus_bridge
  import mpu_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  xm_ale,
  input  logic                  xm_rd_n,
  input  logic                  xm_wr_n,
  input  logic [7:0]            xm_addr_hi,
  input  logic [7:0]            xm_ad_in,
  output logic [7:0]            xm_data_out,
  output logic                  xm_data_oe,
  output logic                  mpu_en,
  output logic                  mpu_rd,
  output logic                  mpu_wr,
  output logic [1:0]            mpu_be,
  output logic [ADDR_WIDTH-1:0] mpu_addr,
  output logic [DATA_WIDTH-1:0] mpu_data_out,
  input  logic [DATA_WIDTH-1:0] mpu_data_in,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(RD_LATENCY + 2);

  // Strobes and the address/data bus share one synchroniser so they stay aligned.
  logic [18:0] sync_in, sync_s1, sync_s2;
  logic        unused_sync_s1;

  assign sync_in = {xm_ale, xm_rd_n, xm_wr_n, xm_addr_hi, xm_ad_in};

  bus_synchronizer #(
    .WIDTH  (19),
    .RST_VAL({1'b0, 1'b1, 1'b1, 16'h0000})
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sync_in),
    .s1   (sync_s1),
    .s2   (sync_s2)
  );

  assign unused_sync_s1 = ^sync_s1[15:0];

  logic       ale_s1, ale_s2, rd_n_s1, rd_n_s2, wr_n_s1, wr_n_s2;
  logic [7:0] addr_hi_s2, ad_s2;
  logic       ale_fall, rd_fall, rd_rise, wr_rise;

  assign {ale_s1, rd_n_s1, wr_n_s1} = sync_s1[18:16];
  assign {ale_s2, rd_n_s2, wr_n_s2} = sync_s2[18:16];
  assign addr_hi_s2 = sync_s2[15:8];
  assign ad_s2      = sync_s2[7:0];

  assign ale_fall = ale_s2 & ~ale_s1;
  assign rd_fall  = rd_n_s2 & ~rd_n_s1;
  assign rd_rise  = ~rd_n_s2 & rd_n_s1;
  assign wr_rise  = ~wr_n_s2 & wr_n_s1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            xm_data_out_q, xm_data_out_d;
  logic                  xm_data_oe_q, xm_data_oe_d;
  logic                  mpu_en_q, mpu_en_d;
  logic                  mpu_rd_q, mpu_rd_d;
  logic                  mpu_wr_q, mpu_wr_d;
  logic [1:0]            mpu_be_q, mpu_be_d;
  logic [ADDR_WIDTH-1:0] mpu_addr_q, mpu_addr_d;
  logic [DATA_WIDTH-1:0] mpu_data_out_q, mpu_data_out_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    xm_data_out_d  = xm_data_out_q;
    xm_data_oe_d   = xm_data_oe_q;
    mpu_en_d       = 1'b0;
    mpu_rd_d       = 1'b0;
    mpu_wr_d       = 1'b0;
    mpu_be_d       = mpu_be_q;
    mpu_addr_d     = mpu_addr_q;
    mpu_data_out_d = mpu_data_out_q;
    overrun_d      = 1'b0;

    if (ale_fall) begin
      addr_d = ADDR_WIDTH'({addr_hi_s2, ad_s2});
    end

    // mpu_addr/mpu_be double as the in-flight transaction's private address copy.
    case (state_q)
      IDLE: begin
        if (wr_rise && rd_fall) begin
          overrun_d = 1'b1;
        end else if (wr_rise) begin
          state_d        = WRITE;
          mpu_addr_d     = addr_q >> 1;
          mpu_be_d       = be_for(addr_q[0]);
          mpu_data_out_d = DATA_WIDTH'({ad_s2, ad_s2});
        end else if (rd_fall) begin
          state_d    = RD_REQ;
          mpu_addr_d = addr_q >> 1;
          mpu_be_d   = be_for(addr_q[0]);
        end
      end
      WRITE: begin
        mpu_en_d = 1'b1;
        mpu_wr_d = 1'b1;
        state_d  = IDLE;
      end
      RD_REQ: begin
        mpu_en_d = 1'b1;
        mpu_rd_d = 1'b1;
        cnt_d    = '0;
        state_d  = RD_WAIT;
        if (rd_rise) begin
          state_d   = IDLE;
          overrun_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (rd_rise) begin
          state_d   = IDLE;
          overrun_d = 1'b1;
        end else if (cnt_q == CNT_W'(RD_LATENCY)) begin
          xm_data_out_d = (mpu_be_q == BE_ODD) ? mpu_data_in[15:8] : mpu_data_in[7:0];
          xm_data_oe_d  = 1'b1;
          state_d       = RD_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_HOLD: begin
        if (rd_rise) begin
          xm_data_oe_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (wr_rise || rd_fall)) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      cnt_q          <= '0;
      xm_data_out_q  <= '0;
      xm_data_oe_q   <= 1'b0;
      mpu_en_q       <= 1'b0;
      mpu_rd_q       <= 1'b0;
      mpu_wr_q       <= 1'b0;
      mpu_be_q       <= '0;
      mpu_addr_q     <= '0;
      mpu_data_out_q <= '0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      xm_data_out_q  <= xm_data_out_d;
      xm_data_oe_q   <= xm_data_oe_d;
      mpu_en_q       <= mpu_en_d;
      mpu_rd_q       <= mpu_rd_d;
      mpu_wr_q       <= mpu_wr_d;
      mpu_be_q       <= mpu_be_d;
      mpu_addr_q     <= mpu_addr_d;
      mpu_data_out_q <= mpu_data_out_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign xm_data_out  = xm_data_out_q;
  assign xm_data_oe   = xm_data_oe_q;
  assign mpu_en       = mpu_en_q;
  assign mpu_rd       = mpu_rd_q;
  assign mpu_wr       = mpu_wr_q;
  assign mpu_be       = mpu_be_q;
  assign mpu_addr     = mpu_addr_q;
  assign mpu_data_out = mpu_data_out_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_mpu_bus_bridge.sv
// Directed bench for mpu_bus_bridge: host writes/reads, strobe overruns and mid-read reset.
module tb_mpu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        xm_ale, xm_rd_n, xm_wr_n;
  logic [7:0]  xm_addr_hi, xm_ad_in;
  logic [7:0]  xm_data_out;
  logic        xm_data_oe;
  logic        mpu_en, mpu_rd, mpu_wr;
  logic [1:0]  mpu_be;
  logic [15:0] mpu_addr, mpu_data_out, mpu_data_in;
  logic        busy, overrun;

  int errors = 0;
  int checks = 0;
  int ov_cnt = 0, rd_cnt = 0, wr_cnt = 0, oe_cnt = 0;
  logic        rd_dly = 1'b0;
  logic [15:0] rd_word = 16'h0000;

  always #5 clk = ~clk;

  mpu_bus_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RD_LATENCY(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .xm_ale      (xm_ale),
    .xm_rd_n     (xm_rd_n),
    .xm_wr_n     (xm_wr_n),
    .xm_addr_hi  (xm_addr_hi),
    .xm_ad_in    (xm_ad_in),
    .xm_data_out (xm_data_out),
    .xm_data_oe  (xm_data_oe),
    .mpu_en      (mpu_en),
    .mpu_rd      (mpu_rd),
    .mpu_wr      (mpu_wr),
    .mpu_be      (mpu_be),
    .mpu_addr    (mpu_addr),
    .mpu_data_out(mpu_data_out),
    .mpu_data_in (mpu_data_in),
    .busy        (busy),
    .overrun     (overrun)
  );

  // Core model: read data is valid only RD_LATENCY (=1) cycle after the read strobe.
  always @(posedge clk) rd_dly <= mpu_rd;
  assign mpu_data_in = rd_dly ? rd_word : 16'hDEAD;

  always @(negedge clk) begin
    if (!reset) begin
      if (overrun)    ov_cnt <= ov_cnt + 1;
      if (mpu_rd)     rd_cnt <= rd_cnt + 1;
      if (mpu_wr)     wr_cnt <= wr_cnt + 1;
      if (xm_data_oe) oe_cnt <= oe_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic host_ale(input logic [15:0] a);
    xm_addr_hi = a[15:8];
    xm_ad_in   = a[7:0];
    xm_ale     = 1'b1;
    cyc(3);
    xm_ale = 1'b0;
    cyc(3);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic [15:0] exp_addr,
                          input logic [1:0] exp_be, input logic [15:0] exp_data);
    int n;
    host_ale(a);
    xm_ad_in = d;
    xm_wr_n  = 1'b0;
    cyc(4);
    xm_wr_n = 1'b1;
    n = 0;
    while (!mpu_wr && n < 10) begin
      cyc();
      n++;
    end
    chk("wr_latency", (n >= 3 && n <= 4), 1);
    chk("wr_en", mpu_en, 1);
    chk("wr_rd_excl", mpu_rd, 0);
    chk("wr_addr", mpu_addr, exp_addr);
    chk("wr_be", mpu_be, exp_be);
    chk("wr_data", mpu_data_out, exp_data);
    cyc();
    chk("wr_pulse_width", mpu_wr, 0);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] word, input logic [15:0] exp_addr,
                         input logic [1:0] exp_be, input logic [7:0] exp_byte);
    int n;
    int rd0;
    rd_word = word;
    host_ale(a);
    rd0 = rd_cnt;
    xm_rd_n = 1'b0;
    n = 0;
    while (!mpu_rd && n < 10) begin
      cyc();
      n++;
    end
    chk("rd_latency", n, 3);
    chk("rd_en", mpu_en, 1);
    chk("rd_wr_excl", mpu_wr, 0);
    chk("rd_addr", mpu_addr, exp_addr);
    chk("rd_be", mpu_be, exp_be);
    while (!xm_data_oe && n < 12) begin
      cyc();
      n++;
    end
    chk("oe_latency", n, 5);
    chk("rd_byte", xm_data_out, exp_byte);
    cyc(2);
    chk("oe_held", xm_data_oe, 1);
    chk("rd_byte_held", xm_data_out, exp_byte);
    chk("busy_in_hold", busy, 1);
    chk("rd_single_pulse", rd_cnt - rd0, 1);
    xm_rd_n = 1'b1;
    n = 0;
    while (xm_data_oe && n < 6) begin
      cyc();
      n++;
    end
    chk("oe_release", (n >= 1 && n <= 3), 1);
    cyc();
    chk("busy_after_rd", busy, 0);
  endtask

  initial begin
    int n, ov0, rd0, wr0, oe0;
    reset = 1'b1;
    xm_ale = 1'b0; xm_rd_n = 1'b1; xm_wr_n = 1'b1;
    xm_addr_hi = 8'h00; xm_ad_in = 8'h00;
    cyc(3);
    chk("rst_data_out", xm_data_out, 0);
    chk("rst_oe", xm_data_oe, 0);
    chk("rst_en", mpu_en, 0);
    chk("rst_rd", mpu_rd, 0);
    chk("rst_wr", mpu_wr, 0);
    chk("rst_be", mpu_be, 0);
    chk("rst_addr", mpu_addr, 0);
    chk("rst_mpu_data", mpu_data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    cyc(2);

    do_write(16'h1235, 8'hA5, 16'h091A, 2'b10, 16'hA5A5);
    do_read(16'h0200, 16'h1234, 16'h0100, 2'b01, 8'h34);
    do_read(16'h0201, 16'h1234, 16'h0100, 2'b10, 8'h12);
    do_write(16'hFFFF, 8'h3C, 16'h7FFF, 2'b10, 16'h3C3C);
    chk("no_overrun_yet", ov_cnt, 0);

    // Short RD strobe: released before the read data is captured.
    host_ale(16'h0300);
    ov0 = ov_cnt; oe0 = oe_cnt;
    xm_rd_n = 1'b0;
    cyc(3);
    xm_rd_n = 1'b1;
    cyc(8);
    chk("short_rd_overrun", ov_cnt - ov0, 1);
    chk("short_rd_no_oe", oe_cnt - oe0, 0);
    chk("short_rd_idle", busy, 0);

    // RD fall and WR rise detected together in IDLE.
    ov0 = ov_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    xm_wr_n = 1'b0;
    cyc(4);
    xm_wr_n = 1'b1;
    xm_rd_n = 1'b0;
    cyc(8);
    chk("both_overrun", ov_cnt - ov0, 1);
    chk("both_no_rd", rd_cnt - rd0, 0);
    chk("both_no_wr", wr_cnt - wr0, 0);
    chk("both_idle", busy, 0);
    xm_rd_n = 1'b1;
    cyc(4);
    chk("idle_rd_rise_quiet", ov_cnt - ov0, 1);

    // Second host strobe while a read is being held on the pad.
    rd_word = 16'h5678;
    host_ale(16'h0200);
    xm_rd_n = 1'b0;
    n = 0;
    while (!xm_data_oe && n < 12) begin
      cyc();
      n++;
    end
    chk("hold_oe_reached", xm_data_oe, 1);
    ov0 = ov_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    xm_wr_n = 1'b0;
    cyc(3);
    xm_wr_n = 1'b1;
    cyc(5);
    chk("hold_overrun", ov_cnt - ov0, 1);
    chk("hold_no_wr", wr_cnt - wr0, 0);
    chk("hold_no_second_rd", rd_cnt - rd0, 0);
    chk("hold_oe_kept", xm_data_oe, 1);
    chk("hold_byte_kept", xm_data_out, 8'h78);
    xm_rd_n = 1'b1;
    cyc(4);
    chk("hold_released", xm_data_oe, 0);

    // Reset while a read is on the pad.
    rd_word = 16'h9ABC;
    host_ale(16'h0201);
    xm_rd_n = 1'b0;
    n = 0;
    while (!xm_data_oe && n < 12) begin
      cyc();
      n++;
    end
    chk("mid_rd_byte", xm_data_out, 8'h9A);
    rd0 = rd_cnt; wr0 = wr_cnt;
    reset = 1'b1;
    xm_rd_n = 1'b1;
    cyc();
    chk("mid_rst_oe", xm_data_oe, 0);
    chk("mid_rst_data_out", xm_data_out, 0);
    chk("mid_rst_addr", mpu_addr, 0);
    chk("mid_rst_be", mpu_be, 0);
    chk("mid_rst_mpu_data", mpu_data_out, 0);
    chk("mid_rst_busy", busy, 0);
    cyc();
    reset = 1'b0;
    cyc(6);
    chk("post_rst_no_rd", rd_cnt - rd0, 0);
    chk("post_rst_no_wr", wr_cnt - wr0, 0);
    chk("post_rst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
